// File: rtl/relm_div_seq.sv
// Initiator-side sequencer for the custom-unit divide: DIV -> DIVINIT -> DIVLOOP* -> DIVMOD.
// Define RELM_DIV_SEQ_SIGNED_EN for two's-complement operands with sign fix-up on DONE entry.
module relm_div_seq #(
  parameter int WD  = 32,
  parameter int WOP = 5,
  parameter int WC  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [WD-1:0]       n_in,
  input  logic [WD-1:0]       d_in,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [WD-1:0]       q_out,
  output logic [WD-1:0]       r_out,
  output logic                dz_out,
  output logic [WOP-1:0]      cu_op_out,
  output logic                cu_opb_out,
  output logic [WD-1:0]       cu_x_out,
  output logic [WD-1:0]       cu_xb_out,
  output logic [WD-1:0]       cu_a_out,
  output logic [WC+WD-1:0]    cu_cb_out,
  input  logic [WD-1:0]       cu_a_in,
  input  logic [WC+WD-1:0]    cu_cb_in,
  input  logic                cu_retry_in,
  input  logic [WD-1:0]       cu_mul_a_in,
  input  logic [WD-1:0]       cu_mul_x_in,
  output logic [2*WD-1:0]     cu_mul_ax_out
);
  localparam int LW = $clog2(WD);
  localparam logic [WOP-1:0] DIV_OP = WOP'(3'b101);

  typedef enum logic [2:0] {S_IDLE, S_DIV, S_INIT0, S_INIT1, S_LOOP, S_MOD, S_DONE} state_t;
  state_t state;

  logic [WD-1:0]    n_r, d_r, a_r;
  logic [WC+WD-1:0] cb_r;
  logic [WD-1:0]    n_mag, d_mag, q_fix, r_fix;

  function automatic logic [LW-1:0] msb_idx(input logic [WD-1:0] v);
    msb_idx = '0;
    for (int i = 0; i < WD; i++) if (v[i]) msb_idx = LW'(i);
  endfunction

`ifdef RELM_DIV_SEQ_SIGNED_EN
  logic neg_q, neg_r;
  assign n_mag = n_in[WD-1] ? -n_in : n_in;
  assign d_mag = d_in[WD-1] ? -d_in : d_in;
  assign q_fix = neg_q ? -cu_cb_in[WD-1:0] : cu_cb_in[WD-1:0];
  assign r_fix = neg_r ? -cu_a_in : cu_a_in;
`else
  assign n_mag = n_in;
  assign d_mag = d_in;
  assign q_fix = cu_cb_in[WD-1:0];
  assign r_fix = cu_a_in;
`endif

  // Combinational on rst so the port reads ready in the very first cycle after reset.
  assign start_ready = (state == S_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      res_valid     <= 1'b0;
      q_out         <= '0;
      r_out         <= '0;
      dz_out        <= 1'b0;
      n_r           <= '0;
      d_r           <= '0;
      a_r           <= '0;
      cb_r          <= '0;
      cu_mul_ax_out <= '0;
`ifdef RELM_DIV_SEQ_SIGNED_EN
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
`endif
    end else begin
      cu_mul_ax_out <= (2*WD)'(cu_mul_a_in) * (2*WD)'(cu_mul_x_in);
      case (state)
        S_IDLE: if (start_valid) begin
          n_r    <= n_mag;
          d_r    <= d_mag;
          dz_out <= 1'b0;
`ifdef RELM_DIV_SEQ_SIGNED_EN
          neg_q  <= n_in[WD-1] ^ d_in[WD-1];
          neg_r  <= n_in[WD-1];
`endif
          if (d_in == '0) begin
            q_out     <= '1;
            r_out     <= n_in;
            dz_out    <= 1'b1;
            res_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            state <= S_DIV;
          end
        end
        // Starting quotient bit: MSB(N) scaled down by MSB position of D (0 if D is wider).
        S_DIV: if (!cu_retry_in) begin
          cb_r  <= cu_cb_in;
          a_r   <= cu_a_in >> msb_idx(cu_cb_in[WD-1:0]);
          state <= S_INIT0;
        end
        S_INIT0: if (!cu_retry_in) state <= S_INIT1;
        S_INIT1: if (!cu_retry_in) begin
          cb_r  <= cu_cb_in;
          a_r   <= cu_a_in;
          state <= (a_r == '0) ? S_MOD : S_LOOP;
        end
        S_LOOP: if (!cu_retry_in) begin
          cb_r  <= cu_cb_in;
          a_r   <= cu_a_in;
          state <= (cu_a_in == '0) ? S_MOD : S_LOOP;
        end
        S_MOD: if (!cu_retry_in) begin
          q_out     <= q_fix;
          r_out     <= r_fix;
          res_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cu_op_out  = '0;
    cu_opb_out = 1'b0;
    cu_x_out   = '0;
    cu_xb_out  = '0;
    cu_a_out   = '0;
    cu_cb_out  = '0;
    case (state)
      S_DIV: begin
        cu_op_out = DIV_OP;
        cu_a_out  = n_r;
        cu_xb_out = d_r;
      end
      S_INIT0, S_INIT1, S_LOOP, S_MOD: begin
        cu_op_out  = DIV_OP;
        cu_opb_out = 1'b1;
        cu_a_out   = a_r;
        cu_cb_out  = cb_r;
        cu_x_out[WOP+1:WOP] = (state == S_LOOP) ? 2'b10 :
                              (state == S_MOD)  ? 2'b11 : 2'b01;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_relm_div_seq.sv
// Directed bench for relm_div_seq with a behavioural custom-unit model closing the loop.
module tb_relm_div_seq;
  logic         clk = 1'b0;
  logic         rst, start_valid, start_ready, res_valid, res_ready, dz_out;
  logic [31:0]  n_in, d_in, q_out, r_out;
  logic [4:0]   cu_op_out;
  logic         cu_opb_out, cu_retry_in;
  logic [31:0]  cu_x_out, cu_xb_out, cu_a_out, cu_a_in, cu_mul_a_in, cu_mul_x_in;
  logic [95:0]  cu_cb_out, cu_cb_in;
  logic [63:0]  cu_mul_ax_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  relm_div_seq dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .n_in(n_in), .d_in(d_in), .res_valid(res_valid), .res_ready(res_ready),
    .q_out(q_out), .r_out(r_out), .dz_out(dz_out),
    .cu_op_out(cu_op_out), .cu_opb_out(cu_opb_out), .cu_x_out(cu_x_out),
    .cu_xb_out(cu_xb_out), .cu_a_out(cu_a_out), .cu_cb_out(cu_cb_out),
    .cu_a_in(cu_a_in), .cu_cb_in(cu_cb_in), .cu_retry_in(cu_retry_in),
    .cu_mul_a_in(cu_mul_a_in), .cu_mul_x_in(cu_mul_x_in), .cu_mul_ax_out(cu_mul_ax_out)
  );

  function automatic logic [31:0] onehot_msb(input logic [31:0] v);
    onehot_msb = 32'd0;
    for (int i = 0; i < 32; i++) if (v[i]) onehot_msb = 32'd1 << i;
  endfunction

  // Unit model: cb = {remainder, shifted divisor, quotient acc}, a = current quotient bit.
  logic [31:0] lr, lc, lb, la;
  always_comb begin
    cu_a_in = '0; cu_cb_in = '0; cu_mul_a_in = '0; cu_mul_x_in = '0;
    lr = '0; lc = '0; lb = '0; la = '0;
    if (cu_op_out[2:0] == 3'b101) begin
      if (!cu_opb_out) begin
        cu_cb_in = {cu_a_out, cu_xb_out, onehot_msb(cu_xb_out)};
        cu_a_in  = onehot_msb(cu_a_out);
      end else begin
        case (cu_x_out[6:5])
          2'b01: begin
            cu_mul_a_in = cu_a_out;
            cu_mul_x_in = cu_cb_out[63:32];
            cu_cb_in    = {cu_cb_out[95:64], cu_mul_ax_out[31:0], 32'd0};
            cu_a_in     = cu_a_out;
          end
          2'b10: begin
            lr = cu_cb_out[95:64]; lc = cu_cb_out[63:32]; lb = cu_cb_out[31:0]; la = cu_a_out;
            for (int k = 0; k < 2; k++) begin
              if (la != 0 && lc <= lr) begin lr = lr - lc; lb = lb | la; end
              la = la >> 1; lc = lc >> 1;
            end
            cu_cb_in = {lr, lc, lb};
            cu_a_in  = la;
          end
          2'b11: begin
            cu_a_in  = cu_cb_out[95:64];
            cu_cb_in = cu_cb_out;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Call at posedge+1 with DUT idle; cyc = cycle in which res_valid is first seen.
  task automatic run_div(input logic [31:0] n, input logic [31:0] d, output int cyc);
    n_in = n; d_in = d; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0; cyc = 1;
    while (!res_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
  endtask

  task automatic wait_res(inout int cyc);
    while (!res_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
  endtask

  task automatic take_res();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] n, d, q, r;
    logic        dz;
    int          cyc;
  } vec_t;

  vec_t tbl[$];
  int   cyc;
  logic seen;

  initial begin
    tbl.push_back('{32'd100,  32'd7,    32'd14,         32'd2,   1'b0, 8});
    tbl.push_back('{32'd5,    32'd9,    32'd0,          32'd5,   1'b0, 5});
    tbl.push_back('{32'd7,    32'd7,    32'd1,          32'd0,   1'b0, 6});
    tbl.push_back('{32'd123,  32'd0,    32'hFFFFFFFF,   32'd123, 1'b1, 1});
    tbl.push_back('{32'd0,    32'd5,    32'd0,          32'd0,   1'b0, 5});
    tbl.push_back('{32'd1000, 32'd1000, 32'd1,          32'd0,   1'b0, 6});
`ifdef RELM_DIV_SEQ_SIGNED_EN
    tbl.push_back('{-32'sd100, 32'd7,     -32'sd14, -32'sd2,   1'b0, 8});
    tbl.push_back('{32'd100,   -32'sd7,   -32'sd14, 32'd2,     1'b0, 8});
    tbl.push_back('{-32'sd7,   -32'sd7,   32'd1,    32'd0,     1'b0, 6});
    tbl.push_back('{-32'sd123, 32'd0,     32'hFFFFFFFF, -32'sd123, 1'b1, 1});
`else
    tbl.push_back('{32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0, 1'b0, 21});
    tbl.push_back('{32'h80000000, 32'd3,        32'h2AAAAAAA, 32'd2, 1'b0, 21});
    tbl.push_back('{32'd1,        32'hFFFFFFFF, 32'd0,        32'd1, 1'b0, 5});
`endif

    rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0; cu_retry_in = 1'b0;
    n_in = '0; d_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start_ready", start_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_qrdz", {q_out, r_out, dz_out}, 0);
    chk("rst_cu_ops", {cu_op_out, cu_opb_out, cu_x_out, cu_xb_out, cu_a_out}, 0);
    chk("rst_cu_cb", cu_cb_out, 0);
    chk("rst_mul", cu_mul_ax_out, 0);
    rst = 1'b0; #1;
    chk("post_rst_ready", start_ready, 1);

    foreach (tbl[i]) begin
      run_div(tbl[i].n, tbl[i].d, cyc);
      chk($sformatf("q[%0d]", i), q_out, tbl[i].q);
      chk($sformatf("r[%0d]", i), r_out, tbl[i].r);
      chk($sformatf("dz[%0d]", i), dz_out, tbl[i].dz);
      chk($sformatf("lat[%0d]", i), cyc, tbl[i].cyc);
      take_res();
      chk($sformatf("idle[%0d]", i), {res_valid, start_ready}, 2'b01);
    end

    // Retry in INIT1 and in the first LOOP cycle: operands must repeat unchanged.
    n_in = 32'd100; d_in = 32'd7; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0; cyc = 1;
    chk("div_ops", {cu_op_out, cu_opb_out, cu_a_out, cu_xb_out}, {5'd5, 1'b0, 32'd100, 32'd7});
    @(posedge clk); #1; cyc++;
    chk("init0_ops", {cu_opb_out, cu_x_out, cu_a_out}, {1'b1, 32'h20, 32'd16});
    chk("init0_cb", cu_cb_out, {32'd100, 32'd7, 32'd4});
    @(posedge clk); #1; cyc++;
    cu_retry_in = 1'b1;
    chk("init1_ops", {cu_x_out, cu_a_out, cu_mul_ax_out}, {32'h20, 32'd16, 64'd112});
    chk("init1_cb", cu_cb_out, {32'd100, 32'd7, 32'd4});
    @(posedge clk); #1; cyc++;
    cu_retry_in = 1'b0;
    chk("init1_rep_ops", {cu_x_out, cu_a_out, cu_mul_ax_out}, {32'h20, 32'd16, 64'd112});
    chk("init1_rep_cb", cu_cb_out, {32'd100, 32'd7, 32'd4});
    @(posedge clk); #1; cyc++;
    cu_retry_in = 1'b1;
    chk("loop_ops", {cu_x_out, cu_a_out}, {32'h40, 32'd16});
    chk("loop_cb", cu_cb_out, {32'd100, 32'd112, 32'd0});
    @(posedge clk); #1; cyc++;
    cu_retry_in = 1'b0;
    chk("loop_rep_ops", {cu_x_out, cu_a_out}, {32'h40, 32'd16});
    chk("loop_rep_cb", cu_cb_out, {32'd100, 32'd112, 32'd0});
    wait_res(cyc);
    chk("retry_qr", {q_out, r_out, dz_out}, {32'd14, 32'd2, 1'b0});
    chk("retry_lat", cyc, 10);

    // Result held under backpressure; new starts refused.
    chk("hold_idle_ops", cu_op_out, 5'd0);
    start_valid = 1'b1; n_in = 32'd5; d_in = 32'd9;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold[%0d]", k), {res_valid, start_ready, q_out, r_out},
          {1'b1, 1'b0, 32'd14, 32'd2});
    end
    start_valid = 1'b0;
    take_res();
    chk("hold_release", {res_valid, start_ready}, 2'b01);

    // Reset in the middle of a long LOOP run.
    n_in = 32'hFFFFFFFF; d_in = 32'd1; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_loop", {cu_opb_out, cu_x_out[6:5]}, 3'b110);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_state", {res_valid, start_ready, cu_op_out, cu_opb_out}, 0);
    chk("midrst_qr", {q_out, r_out, dz_out, cu_a_out}, 0);
    rst = 1'b0; #1;
    chk("midrst_ready", start_ready, 1);
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (res_valid || cu_op_out != 0) seen = 1'b1;
    end
    chk("midrst_quiet", seen, 0);

    run_div(32'd7, 32'd7, cyc);
    chk("recover_qr", {q_out, r_out}, {32'd1, 32'd0});
    chk("recover_lat", cyc, 6);
    take_res();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule
